// File: rtl/fwd_scoreboard_pkg.sv
// rtl/fwd_scoreboard_pkg.sv - shared constants, entry record and latency clamp for forwarding_scoreboard
package fwd_scoreboard_pkg;

    localparam int SEL_RF   = 0;
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    // Entry fields are sized for the largest supported configuration (REG_AW <= 16, DEPTH <= 7)
    localparam int RD_W_MAX = 16;
    localparam int LAT_W    = 3;

    typedef struct packed {
        logic                valid;
        logic [RD_W_MAX-1:0] rd;
        logic [LAT_W-1:0]    lat;
    } entry_t;

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat, input int depth);
        if (lat == '0) begin
            return LAT_W'(LAT_ALU);
        end
        if (int'(lat) > depth) begin
            return LAT_W'(depth);
        end
        return lat;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// rtl/fwd_src_match.sv - priority comparator for one source operand over all tracked stages
module fwd_src_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                      rs_valid,
    input  logic [REG_AW-1:0]         rs,
    input  logic [DEPTH-1:0]          ent_valid,
    input  logic [DEPTH*RD_W_MAX-1:0] ent_rd,
    input  logic [DEPTH*LAT_W-1:0]    ent_lat,
    output logic [SEL_W-1:0]          sel,
    output logic                      stall_req
);

    logic             hit;
    logic [SEL_W-1:0] hit_stage;
    logic [LAT_W-1:0] hit_lat;

    always_comb begin
        sel       = SEL_W'(SEL_RF);
        stall_req = 1'b0;
        hit       = 1'b0;
        hit_stage = '0;
        hit_lat   = '0;
        // Scan oldest to youngest so the youngest matching writer is the one left standing
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_valid[k] && (ent_rd[k*RD_W_MAX +: RD_W_MAX] == RD_W_MAX'(rs))) begin
                hit       = 1'b1;
                hit_stage = SEL_W'(k + 1);
                hit_lat   = ent_lat[k*LAT_W +: LAT_W];
            end
        end
        if (rs_valid && hit) begin
            if (int'(hit_stage) >= int'(hit_lat)) begin
                sel = hit_stage;
            end else begin
                stall_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// rtl/forwarding_scoreboard.sv - in-flight writer record, forward selects and load-use stall
// Optional statistics counters are enabled with FWD_SCOREBOARD_STATS_EN.
module forwarding_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    localparam int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      ex_valid,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_regwrite,
    input  logic [SEL_W-1:0]          ex_lat,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [DEPTH-1:0]          stage_valid
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]               stat_stall_cnt,
    output logic [31:0]               stat_fwd_cnt
`endif
);

    entry_t                    entries [DEPTH];
    entry_t                    new_entry;
    logic [DEPTH-1:0]          ent_valid;
    logic [DEPTH*RD_W_MAX-1:0] ent_rd;
    logic [DEPTH*LAT_W-1:0]    ent_lat;
    logic [NUM_SRC*SEL_W-1:0]  raw_sel;
    logic [NUM_SRC-1:0]        stall_req;
    logic                      stall_raw;

    always_comb begin
        new_entry       = '0;
        new_entry.valid = ex_valid && ex_regwrite && (ex_rd != '0);
        if (new_entry.valid) begin
            new_entry.rd  = RD_W_MAX'(ex_rd);
            new_entry.lat = clamp_lat(LAT_W'(ex_lat), DEPTH);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign ent_valid[k]                      = entries[k].valid;
        assign ent_rd[k*RD_W_MAX +: RD_W_MAX]    = entries[k].rd;
        assign ent_lat[k*LAT_W +: LAT_W]         = entries[k].lat;
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] rs_i;
        assign rs_i = ex_rs[i*REG_AW +: REG_AW];

        fwd_src_match #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH)
        ) u_match (
            .rs_valid  (ex_valid && (rs_i != '0)),
            .rs        (rs_i),
            .ent_valid (ent_valid),
            .ent_rd    (ent_rd),
            .ent_lat   (ent_lat),
            .sel       (raw_sel[i*SEL_W +: SEL_W]),
            .stall_req (stall_req[i])
        );
    end

    assign stall_raw   = |stall_req;
    // Entries may still hold stale writers during the reset cycle, so outputs are masked
    assign stall       = stall_raw && !rst;
    assign fwd_sel     = rst ? '0 : raw_sel;
    assign stage_valid = rst ? '0 : ent_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries[k] <= '0;
            end
        end else if (!freeze) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                entries[k] <= entries[k-1];
            end
            entries[0] <= stall_raw ? '0 : new_entry;
        end
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] fwd_n;
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_n = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (raw_sel[i*SEL_W +: SEL_W] != '0) begin
                fwd_n = fwd_n + 32'd1;
            end
        end
        fwd_sum = {1'b0, stat_fwd_cnt} + {1'b0, fwd_n};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cnt <= '0;
            stat_fwd_cnt   <= '0;
        end else if (!freeze) begin
            if (stall_raw) begin
                if (stat_stall_cnt != '1) begin
                    stat_stall_cnt <= stat_stall_cnt + 32'd1;
                end
            end else begin
                stat_fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
- Parametrised successor to the 2-stage, 2-operand forwarding logic.
- Keeps its own registered record of in-flight writers across DEPTH post-EX stages; stage 1 = EXE/MEM, stage DEPTH = writeback.
- Produces a forward-select per source operand of the EX-stage instruction.
- Raises a stall when the youngest matching producer has not yet produced its result (generalised load-use), supporting per-instruction result latency.

Parameters:
- REG_AW, 5, register-address width.
- NUM_SRC, 2, number of source operands checked for the EX instruction.
- DEPTH, 2, number of tracked post-EX stages (min 2, max 7).
- SEL_W, $clog2(DEPTH+1), width of one select field (derived; not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- freeze  in  1  global pipeline hold (e.g. memory busy); no stage advances.
- ex_valid  in  1  EX-stage instruction is real (0 = bubble or flushed).
- ex_rd  in  REG_AW  destination of the EX instruction.
- ex_regwrite  in  1  EX instruction writes ex_rd.
- ex_lat  in  SEL_W  stage index at which its result becomes forwardable (ALU = 1, load = 2, 1..DEPTH).
- ex_rs  in  NUM_SRC*REG_AW  source addresses; source i is in bits [i*REG_AW +: REG_AW].
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, k = take result from stage k.
- stall  out  1  hold EX and earlier stages; a bubble enters stage 1.
- stage_valid  out  DEPTH  debug: entry k-1 holds a live writer.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst is high at a rising edge, all entries are cleared (valid = 0, rd = 0, lat = 0).
- Outputs during and after reset: while rst is high, fwd_sel = 0, stall = 0 and stage_valid = 0, regardless of other inputs. After release, outputs stay 0 until an entry is loaded.
- Entry contents: valid, rd, lat. An entry is valid only if ex_valid && ex_regwrite && ex_rd != 0 at capture.
- Advance (freeze = 0 and stall = 0):
  - Entry k moves to entry k+1.
  - Entry DEPTH is discarded, because the register file is written that cycle with write-before-read.
  - Entry 1 captures the EX instruction.
- Stall (freeze = 0, stall = 1): entries 1..DEPTH-1 shift to 2..DEPTH, and entry 1 becomes invalid (bubble).
- freeze = 1: all entries hold. freeze takes priority over stall.
- Combinational match: for each source i with ex_valid = 1 and rs_i != 0, find the smallest k where entry k is valid and rd == rs_i.
  - No match: sel = 0.
  - Match with k >= entry.lat: sel = k.
  - Match with k < entry.lat: sel = 0 and that source requests a stall.
  - stall = OR of all source requests.
- Youngest producer always wins. An older ready producer of the same rd must not be chosen while a younger unready one exists.
- rs == 0 never forwards and never stalls.
- Latency rules: ex_lat = 0 is treated as 1. ex_lat > DEPTH is treated as DEPTH.
- Timing: fwd_sel and stall are combinational from entries and current inputs, with zero-cycle latency to the datapath mux. Entries update on the edge.
- Reset mid-operation: all in-flight writers are forgotten at that edge. The next cycle forwards nothing.

Optional Feature:
- Macro: FWD_SCOREBOARD_STATS_EN.
- When defined:
  - Adds outputs stat_stall_cnt [31:0] and stat_fwd_cnt [31:0].
  - stat_stall_cnt increments on every non-frozen cycle with stall = 1.
  - stat_fwd_cnt increments by the number of sources with nonzero fwd_sel on every non-frozen, non-stalled cycle.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package fwd_scoreboard_pkg holds:
  - SEL_RF = 0.
  - LAT_ALU = 1.
  - LAT_LOAD = 2.
  - Entry typedef {valid, rd, lat}.
  - Function clamp_lat.
- One sub-module, fwd_src_match: per-source priority comparator over DEPTH entries, returning sel and stall_req. It is instantiated NUM_SRC times with a generate loop.

Test Plan:
- ALU chain:
  - Stimulus: issue x5 = ALU (lat 1); next cycle EX reads rs1 = 5.
  - Required: fwd_sel[0] = 1, stall = 0.
  - Stimulus: one cycle later (no new writer), rs2 = 5.
  - Required: fwd_sel[1] = 2.
- Load-use:
  - Stimulus: load x7 (lat 2); next cycle EX reads rs1 = 7.
  - Required: stall = 1 for exactly 1 cycle, stage_valid = 2'b10 after the edge, then fwd_sel[0] = 2 with stall = 0.
- Youngest wins:
  - Stimulus: ALU x3 followed immediately by load x3; EX then reads rs1 = 3.
  - Required: stall = 1 (not sel = 2).
  - Next cycle required: sel = 2.
- x0 and bubbles:
  - Stimulus: writer with rd = 0, or ex_valid = 0 with rd = 4; consumer reads rs = 0 or 4.
  - Required: fwd_sel = 0, stall = 0.
- Freeze and reset:
  - Stimulus: freeze = 1 for 3 cycles holding a load x9 in entry 1.
  - Required: stage_valid constant and stall constant throughout.
  - Stimulus: rst = 1 for one cycle.
  - Required: stage_valid = 0, fwd_sel = 0 next cycle.
- With FWD_SCOREBOARD_STATS_EN:
  - Stimulus: load-use sequence plus one ALU forward.
  - Required: stat_stall_cnt = 1, stat_fwd_cnt = 2.
  - Stimulus: force the counter to 32'hFFFF_FFFF.
  - Required: counter holds at saturation.
